// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB) with trap on illegal opcode or memory timeout
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       br_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] ls_size,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alusrc,
    output logic       aui_pc,
    output logic [4:0] alu_op,
    output logic       instret,
    output logic       illegal_inst,
    output logic       bus_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic [CNT_W-1:0] wait_cnt;

    logic is_r, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic op_legal, mem_busy, mem_rdy, timeout_hit, unused_f3;

    assign is_r     = (op_q == OP_R);
    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_br    = (op_q == OP_BR);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);
    assign unused_f3 = f3_q[2];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // One shared wait counter serves whichever memory port is currently requesting
    assign mem_busy    = ((state == S_FETCH) && imem_req) || (state == S_MEM);
    assign mem_rdy     = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_busy && !mem_rdy && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            op_q         <= '0;
            f3_q         <= '0;
            wait_cnt     <= '0;
            illegal_inst <= 1'b0;
            bus_err      <= 1'b0;
            imem_req     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (timeout_hit) begin
                        state    <= S_TRAP;
                        bus_err  <= 1'b1;
                        imem_req <= 1'b0;
                    end else if (imem_req && imem_ready) begin
                        state    <= S_DECODE;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                        if (imem_req)
                            wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= opcode;
                    f3_q <= func3;
                    if (op_legal) begin
                        state <= S_EXEC;
                    end else begin
                        state        <= S_TRAP;
                        illegal_inst <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end else if (is_ld || is_st) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_st) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (timeout_hit) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= S_TRAP;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Strobes come straight from state so reset and TRAP silence them without a clock
    assign state_o  = state;
    assign ir_we    = (state == S_FETCH) && imem_req && imem_ready;
    assign dmem_req = (state == S_MEM);
    assign dmem_we  = dmem_req && is_st;
    assign ls_size  = (f3_q[1:0] == 2'b11) ? 2'b00 : f3_q[1:0];
    assign reg_we   = (state == S_WB);
    assign instret  = ((state == S_EXEC) && is_br) || ((state == S_MEM) && dmem_ready && is_st) || (state == S_WB);
    assign pc_we    = instret;
    assign pc_sel   = ((state == S_EXEC) && is_br) ? {1'b0, br_taken} :
                      is_jal  ? 2'b01 :
                      is_jalr ? 2'b10 : 2'b00;
    assign wb_sel   = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
    assign alusrc   = !(is_r || is_br);
    assign aui_pc   = is_auipc || is_jal;
    assign alu_op   = is_r ? 5'b00001 : is_br ? 5'b01011 : is_lui ? 5'b01010 : 5'b00010;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl with a per-instruction cycle model
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       br_taken, imem_ready, dmem_ready;
    logic       imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, alusrc, aui_pc;
    logic       instret, illegal_inst, bus_err;
    logic [1:0] ls_size, wb_sel, pc_sel;
    logic [4:0] alu_op;
    logic [2:0] state_o;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ls_size(ls_size), .reg_we(reg_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .alusrc(alusrc), .aui_pc(aui_pc),
        .alu_op(alu_op), .instret(instret), .illegal_inst(illegal_inst), .bus_err(bus_err),
        .state_o(state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        return op inside {R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_illegal", illegal_inst, 0);
        chk("rst_bus_err", bus_err, 0);
        opcode = '0; func3 = '0; br_taken = 0; imem_ready = 0; dmem_ready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", imem_req, 0);
        chk("post_rst_state", state_o, 0);
    endtask

    // dw < 0 means data memory never answers
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                             input int iw, input int dw);
        int  st[$];
        int  mc, memlast, n;
        bit  is_mem, trap_end, writes, last;
        logic [1:0] e_pc_sel, e_wb_sel, e_ls;
        logic [4:0] e_alu;
        is_mem = (op == LD) || (op == ST);
        mc = (dw < 0) ? TMO : dw + 1;
        for (int i = 0; i <= iw; i++) st.push_back(0);
        st.push_back(1);
        if (legal(op)) begin
            st.push_back(2);
            if (is_mem) for (int i = 0; i < mc; i++) st.push_back(3);
            if (op != BR && op != ST && !(op == LD && dw < 0)) st.push_back(4);
        end
        memlast  = iw + 2 + mc;
        trap_end = !legal(op) || (is_mem && dw < 0);
        writes   = !trap_end && op != BR && op != ST;
        n        = st.size();
        e_pc_sel = (op == BR) ? {1'b0, br} : (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
        e_wb_sel = (op == LD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
        e_ls     = (f3[1:0] == 2'b11) ? 2'd0 : f3[1:0];
        e_alu    = (op == R) ? 5'b00001 : (op == BR) ? 5'b01011 : (op == LUI) ? 5'b01010 : 5'b00010;
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1) && !trap_end;
            @(posedge clk); #1;
            opcode = op; func3 = f3; br_taken = br;
            imem_ready = (k == iw);
            dmem_ready = is_mem && dw >= 0 && k == memlast;
            #1;
            chk("state", state_o, st[k]);
            chk("imem_req", imem_req, st[k] == 0);
            chk("ir_we", ir_we, k == iw);
            chk("dmem_req", dmem_req, st[k] == 3);
            chk("reg_we", reg_we, last && writes);
            chk("pc_we", pc_we, last);
            chk("instret", instret, last);
            if (st[k] == 2) begin
                chk("alu_op", alu_op, e_alu);
                chk("alusrc", alusrc, !(op == R || op == BR));
                chk("aui_pc", aui_pc, op == AUIPC || op == JAL);
            end
            if (st[k] == 3) begin
                chk("dmem_we", dmem_we, op == ST);
                chk("ls_size", ls_size, e_ls);
            end
            if (last) begin
                chk("pc_sel", pc_sel, e_pc_sel);
                if (writes) chk("wb_sel", wb_sel, e_wb_sel);
                chk("flags_clear", {illegal_inst, bus_err}, 0);
            end
        end
        if (trap_end) begin
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                imem_ready = 1'($urandom); dmem_ready = 1'($urandom); br_taken = 1'($urandom);
                #1;
                chk("trap_state", state_o, 7);
                chk("trap_strobes", {imem_req, ir_we, dmem_req, reg_we, pc_we, instret}, 0);
                chk("trap_illegal", illegal_inst, !legal(op));
                chk("trap_bus_err", bus_err, legal(op));
            end
            do_reset();
        end
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};
        do_reset();
        run_instr(I, 3'b000, 1'b0, 0, 0);
        run_instr(LD, 3'b010, 1'b0, 0, 3);
        run_instr(BR, 3'b000, 1'b1, 0, 0);
        run_instr(BR, 3'b000, 1'b0, 0, 0);
        run_instr(JALR, 3'b000, 1'b0, 0, 0);
        run_instr(JAL, 3'b000, 1'b0, 0, 0);
        run_instr(ST, 3'b011, 1'b0, 2, 0);
        run_instr(LUI, 3'b000, 1'b0, 3, 0);
        for (int t = 0; t < 40; t++)
            run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        run_instr(ST, 3'b010, 1'b0, 0, -1);
        run_instr(ST, 3'b010, 1'b0, 0, 3);
        run_instr(LD, 3'b001, 1'b0, 1, -1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            opcode = LD; func3 = 3'b000; imem_ready = 1'b1; dmem_ready = 1'b0;
        end
        #1;
        chk("mid_mem_state", state_o, 3);
        do_reset();
        run_instr(R, 3'b000, 1'b0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
